seven_segment_scroller: RTL

- Parametrised N-digit multiplexed seven-segment driver with an internal refresh prescaler.
- Two display modes:
  - static: shows a packed 5-bit glyph-code bus.
  - scroll: shows a run-time-loaded message buffer, scrolled right-to-left with one-shot or loop operation.
- Sits between the system control FSM and the board AN/segment pins.
- Replaces the fixed 4-digit driver with its hard-coded banner.

---
 rtl/seg_pkg.sv | 26 ++
 rtl/seven_segment_glyph.sv | 39 +++
 rtl/seven_segment_scroller.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: glyph codes, segment constants and scroll FSM states.
package seg_pkg;

    localparam logic [4:0] GLYPH_C     = 5'd10;
    localparam logic [4:0] GLYPH_L     = 5'd11;
    localparam logic [4:0] GLYPH_S     = 5'd12;
    localparam logic [4:0] GLYPH_d     = 5'd13;
    localparam logic [4:0] GLYPH_O     = 5'd14;
    localparam logic [4:0] GLYPH_P     = 5'd15;
    localparam logic [4:0] GLYPH_E     = 5'd16;
    localparam logic [4:0] GLYPH_n     = 5'd17;
    localparam logic [4:0] GLYPH_DASH  = 5'd18;
    localparam logic [4:0] GLYPH_BLANK = 5'd19;
    localparam logic [4:0] GLYPH_11    = 5'd20;
    localparam logic [4:0] GLYPH_L2    = 5'd21;
    localparam logic [4:0] GLYPH_V     = 5'd22;

    localparam logic [6:0] SEG_OFF     = 7'b1111111;
    localparam logic [6:0] SEG_UNUSED  = 7'b0110110;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SCROLL = 1'b1
    } scroll_state_e;

endpackage

// File: rtl/seven_segment_glyph.sv
// Combinational glyph-code to active-low {a..g} segment encoder.
module seven_segment_glyph
    import seg_pkg::*;
(
    input  logic [4:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_UNUSED;
        case (code)
            5'd0:        seg = 7'b0000001;
            5'd1:        seg = 7'b1001111;
            5'd2:        seg = 7'b0010010;
            5'd3:        seg = 7'b0000110;
            5'd4:        seg = 7'b1001100;
            5'd5:        seg = 7'b0100100;
            5'd6:        seg = 7'b0100000;
            5'd7:        seg = 7'b0001111;
            5'd8:        seg = 7'b0000000;
            5'd9:        seg = 7'b0000100;
            GLYPH_C:     seg = 7'b0110001;
            GLYPH_L:     seg = 7'b1110001;
            GLYPH_S:     seg = 7'b0100100;
            GLYPH_d:     seg = 7'b1000010;
            GLYPH_O:     seg = 7'b0000001;
            GLYPH_P:     seg = 7'b0011000;
            GLYPH_E:     seg = 7'b0110000;
            GLYPH_n:     seg = 7'b1101010;
            GLYPH_DASH:  seg = 7'b1111110;
            GLYPH_BLANK: seg = SEG_OFF;
            GLYPH_11:    seg = 7'b1001001;
            GLYPH_L2:    seg = 7'b1110001;
            GLYPH_V:     seg = 7'b1000001;
            default:     seg = SEG_UNUSED;
        endcase
    end

endmodule

// File: rtl/seven_segment_scroller.sv
// N-digit multiplexed seven-segment driver with static display and a scrolling
// message buffer, refreshed from an internal prescaler.
module seven_segment_scroller
    import seg_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int SCROLL_DIV  = 64,
    parameter int MSG_MAX     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mode,
    input  logic [5*DIGITS-1:0]   static_bin,
    input  logic                  msg_wr_valid,
    input  logic [4:0]            msg_wr_data,
    output logic                  msg_wr_ready,
    input  logic                  msg_clear,
    input  logic                  scroll_start,
    input  logic                  loop_en,
    output logic                  scroll_busy,
    output logic                  scroll_done,
    output logic [DIGITS-1:0]     AN,
    output logic [6:0]            seven_out
);

    localparam int RW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(DIGITS);
    localparam int FW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam int PW = $clog2(MSG_MAX + 2*DIGITS + 1);
    localparam int LW = $clog2(MSG_MAX + 1);
    localparam int AW = (MSG_MAX > 1) ? $clog2(MSG_MAX) : 1;
    localparam int SW = PW + 1;

    logic [RW-1:0] rcnt;
    logic [IW-1:0] idx;
    logic [FW-1:0] fcnt;
    logic          slot_tick, frame_tick, step_tick;

    scroll_state_e state, state_nxt;
    logic [PW-1:0] pos, pos_nxt, end_pos;
    logic [LW-1:0] len;
    logic [4:0]    msg [MSG_MAX];
    logic          done_nxt, fcnt_clr, wr_en, clr_en;

    logic [DIGITS-1:0][4:0] static_v;
    logic [SW-1:0]          sidx;
    logic [4:0]             cur_code;
    logic [6:0]             cur_seg;

    assign slot_tick  = (rcnt == RW'(REFRESH_DIV-1));
    assign frame_tick = slot_tick && (idx == IW'(DIGITS-1));
    assign step_tick  = frame_tick && (fcnt == FW'(SCROLL_DIV-1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rcnt <= '0;
            idx  <= '0;
            fcnt <= '0;
        end else begin
            rcnt <= slot_tick ? '0 : rcnt + 1'b1;
            if (slot_tick)
                idx <= (idx == IW'(DIGITS-1)) ? '0 : idx + 1'b1;
            if (fcnt_clr)
                fcnt <= '0;
            else if (frame_tick)
                fcnt <= (fcnt == FW'(SCROLL_DIV-1)) ? '0 : fcnt + 1'b1;
        end
    end

    // Clear beats a coincident write by masking ready.
    assign msg_wr_ready = (state == ST_IDLE) && (len < LW'(MSG_MAX)) && !msg_clear;
    assign wr_en        = msg_wr_valid && msg_wr_ready;
    assign clr_en       = msg_clear && (state == ST_IDLE);
    assign end_pos      = PW'(len) + PW'(DIGITS);
    assign scroll_busy  = (state == ST_SCROLL);

    always_comb begin
        state_nxt = state;
        pos_nxt   = pos;
        done_nxt  = 1'b0;
        fcnt_clr  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (scroll_start && (len != '0)) begin
                    state_nxt = ST_SCROLL;
                    pos_nxt   = '0;
                    fcnt_clr  = 1'b1;
                end
            end
            ST_SCROLL: begin
                if (step_tick) begin
                    if (pos == end_pos) begin
                        if (loop_en) begin
                            pos_nxt = '0;
                        end else begin
                            state_nxt = ST_IDLE;
                            done_nxt  = 1'b1;
                        end
                    end else begin
                        pos_nxt = pos + 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            pos         <= '0;
            len         <= '0;
            scroll_done <= 1'b0;
        end else begin
            state       <= state_nxt;
            pos         <= pos_nxt;
            scroll_done <= done_nxt;
            if (clr_en)
                len <= '0;
            else if (wr_en)
                len <= len + 1'b1;
        end
    end

    // Contents are don't-care beyond len, so the array needs no reset.
    always_ff @(posedge clk) begin
        if (wr_en)
            msg[AW'(len)] <= msg_wr_data;
    end

    assign static_v = static_bin;

    // Digit idx maps to stream[pos + DIGITS-1-idx]; the message sits after DIGITS leading blanks.
    always_comb begin
        cur_code = GLYPH_BLANK;
        sidx     = SW'(pos) + SW'(DIGITS-1) - SW'(idx);
        if (!mode)
            cur_code = static_v[idx];
        else if ((sidx >= SW'(DIGITS)) && (sidx < SW'(DIGITS) + SW'(len)))
            cur_code = msg[AW'(sidx - SW'(DIGITS))];
    end

    seven_segment_glyph u_glyph (
        .code (cur_code),
        .seg  (cur_seg)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            AN        <= '1;
            seven_out <= SEG_OFF;
        end else if (slot_tick) begin
            AN        <= ~(DIGITS'(1) << idx);
            seven_out <= cur_seg;
        end
    end

endmodule
